// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: single-outstanding memory requests feeding a small
// {pc, instr} prefetch FIFO, with redirect flush and stale-response discard.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [31:0]      r_fetch_pc;
  logic [31:0]      r_req_pc;
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_pc_mem    [DEPTH];
  logic [31:0]      r_instr_mem [DEPTH];

  logic        w_req;
  logic        w_grant;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_redirect_aligned;

  assign w_redirect_aligned = redirect_pc & ~32'h0000_0003;

  // Redirect suppresses any new request, push or pop in the same cycle
  assign w_req   = (r_state == S_IDLE) && (r_count < CNT_W'(DEPTH)) &&
                   !redirect_valid && !reset;
  assign w_grant = w_req && mem_gnt;
  assign w_push  = (r_state == S_WAIT) && mem_rvalid && !redirect_valid;
  assign w_pop   = (r_count != '0) && id_ready && !redirect_valid;

  assign mem_req  = w_req;
  assign mem_addr = r_fetch_pc;
  assign if_valid = (r_count != '0) && !reset;
  assign if_instr = r_instr_mem[r_rptr];
  assign if_pc    = r_pc_mem[r_rptr];

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:    if (w_grant)    w_state_nxt = S_WAIT;
      S_WAIT:    if (mem_rvalid) w_state_nxt = S_IDLE;
      S_DISCARD: if (mem_rvalid) w_state_nxt = S_IDLE;
      default:                   w_state_nxt = S_IDLE;
    endcase
    // A response arriving with the redirect is consumed now; otherwise drop it later
    if (redirect_valid && (r_state != S_IDLE) && !mem_rvalid) begin
      w_state_nxt = S_DISCARD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Fetch PC and FIFO control
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= w_redirect_aligned;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
    end else begin
      if (w_grant) r_fetch_pc <= r_fetch_pc + 32'd4;
      if (w_push)  r_wptr     <= r_wptr + PTR_W'(1);
      if (w_pop)   r_rptr     <= r_rptr + PTR_W'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset; validity is tracked by r_count
  always_ff @(posedge clk) begin
    if (w_grant) r_req_pc <= r_fetch_pc;
    if (w_push) begin
      r_pc_mem[r_wptr]    <= r_req_pc;
      r_instr_mem[r_wptr] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed, table-driven bench for instr_fetch_unit (RESET_PC=0, DEPTH=2).
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;

  int checks   = 0;
  int failures = 0;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_gnt       (mem_gnt),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .id_ready      (id_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_val;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic gnt, logic rv, logic [31:0] rdata,
                              logic redir, logic [31:0] rpc, logic rdy,
                              logic e_req, logic [31:0] e_addr, logic e_val,
                              logic [31:0] e_pc, logic [31:0] e_instr);
    vec_t v;
    v.rst = rst; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
    v.redir = redir; v.rpc = rpc; v.rdy = rdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_val = e_val;
    v.e_pc = e_pc; v.e_instr = e_instr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at negedge, check outputs 1ns later
  task automatic cyc(input string tag, input vec_t v);
    @(negedge clk);
    reset = v.rst; mem_gnt = v.gnt; mem_rvalid = v.rv; mem_rdata = v.rdata;
    redirect_valid = v.redir; redirect_pc = v.rpc; id_ready = v.rdy;
    #1;
    chk({tag, "_req"}, 32'(mem_req), 32'(v.e_req));
    if (v.e_req) chk({tag, "_addr"}, mem_addr, v.e_addr);
    chk({tag, "_val"}, 32'(if_valid), 32'(v.e_val));
    if (v.e_val) begin
      chk({tag, "_pc"}, if_pc, v.e_pc);
      chk({tag, "_instr"}, if_instr, v.e_instr);
    end
  endtask

  initial begin
    reset = 1'b1; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;

    //             rst gnt rv rdata          rd rpc            rdy  req addr          val pc            instr
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,         0,   0, 32'h0,        0, 32'h0,        32'h0));
    vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,         1,   0, 32'h0,        0, 32'h0,        32'h0));
    // first fetch after reset release
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,         1,   1, 32'h0,        0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 1, 1, 32'h00500093, 0, 32'h0,         1,   0, 32'h0,        0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,         1,   1, 32'h4,        1, 32'h0,        32'h00500093));
    vecs.push_back(mk(0, 1, 1, 32'h11111111, 0, 32'h0,         1,   0, 32'h0,        0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,         1,   1, 32'h8,        1, 32'h4,        32'h11111111));
    // stall decode: fill the FIFO, requests stop at full
    vecs.push_back(mk(0, 1, 1, 32'h22222222, 0, 32'h0,         0,   0, 32'h0,        0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,         0,   1, 32'hC,        1, 32'h8,        32'h22222222));
    vecs.push_back(mk(0, 1, 1, 32'h33333333, 0, 32'h0,         0,   0, 32'h0,        1, 32'h8,        32'h22222222));
    vecs.push_back(mk(0, 1, 1, 32'hDEADBEEF, 0, 32'h0,         0,   0, 32'h0,        1, 32'h8,        32'h22222222));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,         0,   0, 32'h0,        1, 32'h8,        32'h22222222));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,         1,   0, 32'h0,        1, 32'h8,        32'h22222222));
    // grant withheld for 3 cycles: request held stable
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,         0,   1, 32'h10,       1, 32'hC,        32'h33333333));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,         0,   1, 32'h10,       1, 32'hC,        32'h33333333));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,         0,   1, 32'h10,       1, 32'hC,        32'h33333333));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,         0,   1, 32'h10,       1, 32'hC,        32'h33333333));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,         0,   0, 32'h0,        1, 32'hC,        32'h33333333));
    // redirect while WAIT with one entry buffered
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h100,       0,   0, 32'h0,        1, 32'hC,        32'h33333333));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,         0,   0, 32'h0,        0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 1, 1, 32'h00000BAD, 0, 32'h0,         1,   0, 32'h0,        0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,         1,   1, 32'h100,      0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 0, 1, 32'h44444444, 0, 32'h0,         1,   0, 32'h0,        0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,         0,   1, 32'h104,      1, 32'h100,      32'h44444444));
    // redirect to unaligned pc coincident with rvalid in WAIT
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,         0,   1, 32'h104,      1, 32'h100,      32'h44444444));
    vecs.push_back(mk(0, 0, 1, 32'h55555555, 1, 32'h102,       1,   0, 32'h0,        1, 32'h100,      32'h44444444));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,         1,   1, 32'h100,      0, 32'h0,        32'h0));
    // redirect in IDLE beats a pending grant
    vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h200,       1,   0, 32'h0,        0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,         1,   1, 32'h200,      0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 0, 1, 32'h66666666, 0, 32'h0,         1,   0, 32'h0,        0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,         1,   1, 32'h204,      1, 32'h200,      32'h66666666));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,         1,   1, 32'h204,      0, 32'h0,        32'h0));

    foreach (vecs[i]) cyc($sformatf("v%0d", i), vecs[i]);

    // Reset while a request is outstanding with an entry buffered
    cyc("rst_a", mk(0, 1, 0, 32'h0,        0, 32'h0, 0,   1, 32'h204, 0, 32'h0,   32'h0));
    cyc("rst_b", mk(0, 0, 1, 32'h77777777, 0, 32'h0, 0,   0, 32'h0,   0, 32'h0,   32'h0));
    cyc("rst_c", mk(0, 1, 0, 32'h0,        0, 32'h0, 0,   1, 32'h208, 1, 32'h204, 32'h77777777));
    cyc("rst_d", mk(1, 0, 0, 32'h0,        0, 32'h0, 0,   0, 32'h0,   0, 32'h0,   32'h0));
    cyc("rst_e", mk(0, 0, 1, 32'h00000BAD, 0, 32'h0, 0,   1, 32'h0,   0, 32'h0,   32'h0));
    cyc("rst_f", mk(0, 1, 0, 32'h0,        0, 32'h0, 0,   1, 32'h0,   0, 32'h0,   32'h0));
    cyc("rst_g", mk(0, 0, 1, 32'h88888888, 0, 32'h0, 0,   0, 32'h0,   0, 32'h0,   32'h0));
    cyc("rst_h", mk(0, 0, 0, 32'h0,        0, 32'h0, 0,   1, 32'h4,   1, 32'h0,   32'h88888888));

    // Fetch address wraps from the top of the address space to zero
    cyc("wrap_a", mk(0, 0, 0, 32'h0,        1, 32'hFFFF_FFFE, 0,   0, 32'h0,         1, 32'h0,         32'h88888888));
    cyc("wrap_b", mk(0, 1, 0, 32'h0,        0, 32'h0,         1,   1, 32'hFFFF_FFFC, 0, 32'h0,         32'h0));
    cyc("wrap_c", mk(0, 0, 1, 32'h99999999, 0, 32'h0,         1,   0, 32'h0,         0, 32'h0,         32'h0));
    cyc("wrap_d", mk(0, 0, 0, 32'h0,        0, 32'h0,         1,   1, 32'h0,         1, 32'hFFFF_FFFC, 32'h99999999));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
